uart_tx_arbiter: RTL



---
 rtl/uart_tx_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART serializer between N_REQ byte streams, with
// per-packet locking and an optional force-release when a lock owner stalls.
module uart_tx_arbiter #(
   parameter int unsigned N_REQ        = 4,
   parameter int unsigned LOCK_TIMEOUT = 1024,
   parameter int unsigned GW           = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [8*N_REQ-1:0]   req_data,
   input  logic [N_REQ-1:0]     req_last,
   output logic [N_REQ-1:0]     req_ready,
   output logic                 tx_start,
   output logic [7:0]           tx_data,
   input  logic                 tx_busy,
   input  logic                 tx_done,
   output logic [GW-1:0]        grant_id,
   output logic                 lock_active,
   output logic                 lock_timeout
);

   localparam int unsigned CW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
   localparam logic [CW-1:0] CntMax = CW'((LOCK_TIMEOUT == 0) ? 0 : LOCK_TIMEOUT - 1);
   localparam logic [GW-1:0] LastInit = GW'(N_REQ - 1);

   typedef enum logic [1:0] {StIdle, StLoad, StWaitDone} state_e;

   state_e            state_q, state_d;
   logic [GW-1:0]     last_grant_q, last_grant_d;
   logic [GW-1:0]     grant_id_q, grant_id_d;
   logic [N_REQ-1:0]  req_ready_q, req_ready_d;
   logic              tx_start_q, tx_start_d;
   logic [7:0]        tx_data_q, tx_data_d;
   logic              last_q, last_d;
   logic              lock_active_q, lock_active_d;
   logic              lock_timeout_q, lock_timeout_d;
   logic [CW-1:0]     cnt_q, cnt_d;

   logic [7:0]        data_arr [N_REQ];
   logic [N_REQ-1:0]  owner_mask;
   logic [N_REQ-1:0]  cand;
   logic              found;
   logic [GW-1:0]     win;
   logic [GW-1:0]     idx;

   for (genvar i = 0; i < N_REQ; i++) begin : g_data
      assign data_arr[i] = req_data[8*i +: 8];
   end

   // While locked only the owner (the current grant_id) may win.
   always_comb begin
      owner_mask = N_REQ'(1) << grant_id_q;
      cand       = lock_active_q ? (req_valid & owner_mask) : req_valid;
      found      = 1'b0;
      win        = '0;
      idx        = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         idx = GW'((32'(last_grant_q) + 32'd1 + k) % N_REQ);
         if (!found && cand[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_comb begin
      state_d        = state_q;
      last_grant_d   = last_grant_q;
      grant_id_d     = grant_id_q;
      req_ready_d    = '0;
      tx_start_d     = 1'b0;
      tx_data_d      = tx_data_q;
      last_d         = last_q;
      lock_active_d  = lock_active_q;
      lock_timeout_d = 1'b0;
      cnt_d          = '0;
      unique case (state_q)
         StIdle: begin
            if (!tx_busy && found) begin
               state_d     = StLoad;
               grant_id_d  = win;
               req_ready_d = N_REQ'(1) << win;
               tx_start_d  = 1'b1;
               tx_data_d   = data_arr[win];
               last_d      = req_last[win];
            end else if (LOCK_TIMEOUT != 0 && lock_active_q && !req_valid[grant_id_q]) begin
               // last_grant stays at the stalled owner so the others go first.
               if (cnt_q == CntMax) begin
                  lock_active_d  = 1'b0;
                  lock_timeout_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         StLoad: begin
            state_d = StWaitDone;
         end
         StWaitDone: begin
            if (tx_done) begin
               state_d       = StIdle;
               last_grant_d  = grant_id_q;
               lock_active_d = !last_q;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= StIdle;
         last_grant_q   <= LastInit;
         grant_id_q     <= '0;
         req_ready_q    <= '0;
         tx_start_q     <= 1'b0;
         tx_data_q      <= 8'h00;
         last_q         <= 1'b0;
         lock_active_q  <= 1'b0;
         lock_timeout_q <= 1'b0;
         cnt_q          <= '0;
      end else begin
         state_q        <= state_d;
         last_grant_q   <= last_grant_d;
         grant_id_q     <= grant_id_d;
         req_ready_q    <= req_ready_d;
         tx_start_q     <= tx_start_d;
         tx_data_q      <= tx_data_d;
         last_q         <= last_d;
         lock_active_q  <= lock_active_d;
         lock_timeout_q <= lock_timeout_d;
         cnt_q          <= cnt_d;
      end
   end

   assign req_ready    = req_ready_q;
   assign tx_start     = tx_start_q;
   assign tx_data      = tx_data_q;
   assign grant_id     = grant_id_q;
   assign lock_active  = lock_active_q;
   assign lock_timeout = lock_timeout_q;

endmodule
